handshake_monitor: RTL and testbench
====================================

Name: handshake_monitor

Overview:
- Parametrised, bind-able ready/valid protocol monitor for N_CH independent channels. It is the successor to the single-handshake assertion monitor.
- Per-channel FSM checks three properties:
  - valid held until accepted;
  - data stable while stalled;
  - stall bounded by STALL_MAX.
- Counts accepted transfers and keeps sticky error flags plus first-error capture, so simulation and emulation can read protocol health without SVA support.
- Instantiated via bind onto the DUT; all inputs are observe-only taps.

Parameters:
- N_CH, 3, number of monitored handshake channels.
- DATA_W, 5, payload width per channel.
- CNT_W, 16, width of per-channel transfer counter.
- STALL_MAX, 15, stall cycles at which timeout fires (must be >= 1).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESETN  in  1  synchronous, active-low reset.
- valid  in  N_CH  per-channel valid.
- ready  in  N_CH  per-channel ready.
- data  in  N_CH*DATA_W  payloads; channel i occupies bits [i*DATA_W +: DATA_W].
- enable  in  1  when 0, FSMs hold, counters hold, no errors are raised.
- clear_errors  in  1  clears sticky errors and first-error capture.
- xfer_count  out  N_CH*CNT_W  accepted-transfer count per channel, saturating.
- err_drop  out  N_CH  sticky: valid deasserted while stalled.
- err_data  out  N_CH  sticky: data changed while stalled.
- err_timeout  out  N_CH  sticky: stall reached STALL_MAX.
- any_error  out  1  OR of all sticky flags.
- first_err_ch  out  $clog2(N_CH) (min 1)  channel of first error since reset/clear.
- first_err_code  out  2  0 none, 1 drop, 2 data, 3 timeout.

Behaviour:
- Reset (RESETN=0 at posedge):
  - all FSMs go to IDLE;
  - xfer_count, stall counters, all err_* flags, any_error, first_err_ch and first_err_code go to 0;
  - reset mid-stall discards the captured data; no error is raised in the reset cycle.
- Per-channel FSM (states IDLE, STALLED), evaluated only when enable=1:
  - IDLE, valid & ready: transfer; xfer_count+1; stay IDLE.
  - IDLE, valid & !ready: capture data into hold register; stall_cnt=1; go STALLED.
  - IDLE, !valid: stay IDLE.
  - STALLED, !valid: set err_drop; go IDLE; no transfer counted.
  - STALLED, valid & data != hold: set err_data; hold := data; stall accounting continues (ready is still honoured).
  - STALLED, valid & ready: transfer counted; go IDLE. A data mismatch in the same cycle sets err_data and still counts the transfer.
  - STALLED, valid & !ready: stall_cnt += 1, saturating at STALL_MAX.
  - err_timeout sets on the cycle stall_cnt transitions to STALL_MAX. It fires once per stall episode.
- Timing:
  - Error flags and counters are registered, visible the cycle after the offending sampled edge (latency 1).
  - xfer_count saturates at 2^CNT_W-1 and never wraps.
- Sticky errors and first-error capture:
  - clear_errors=1 zeroes err_* and first_err_*.
  - A new error detected in the same cycle as clear_errors wins: its flag is set and it is captured as first error.
  - First-error capture latches only when first_err_code==0 (after accounting for clear in the same cycle).
  - Simultaneous errors across channels: lowest channel index wins.
  - Simultaneous errors on one channel: priority drop > data > timeout.
- enable=0:
  - FSM state, hold register, stall_cnt and counters freeze.
  - clear_errors still acts.
- any_error is combinational OR of the registered flags (no extra latency).

Decomposition:
- Package handshake_monitor_pkg holds:
  - enum ch_state_t {IDLE, STALLED};
  - enum err_code_t {ERR_NONE=0, ERR_DROP=1, ERR_DATA=2, ERR_TIMEOUT=3};
  - a function for the clog2 width minimum of 1.
- Sub-module handshake_monitor_ch (one channel: FSM, hold register, stall counter, xfer counter, three per-cycle error pulses) is generated N_CH times.
- Top level does sticky flags, priority encoding and first-error capture.

Test Plan:
- Back-to-back transfers on ch0 (valid=ready=1 for 10 cycles) -> xfer_count[0]=10, no errors, first_err_code=0.
- ch1 valid=1, data=5'h0A, ready=0 for 3 cycles, then ready=1 -> xfer_count[1]=1, no errors. Then ch1 stalls, valid drops after 2 cycles -> err_drop[1]=1, first_err_ch=1, first_err_code=1, one cycle later.
- ch2 stalled with data 5'h03, data changes to 5'h04 while still stalled -> err_data[2]=1, code=2. Simultaneous drop on ch0 and data error on ch2 in the same cycle -> first_err_ch=0, code=1.
- STALL_MAX=15, ch0 stalled 20 cycles -> err_timeout[0] rises exactly on the 15th stall cycle's update, fires once; later acceptance counts the transfer.
- clear_errors asserted in the same cycle as a new ch1 drop -> all flags cleared except err_drop[1]; first_err_ch=1, code=1.
- CNT_W=4, 20 transfers -> xfer_count saturates at 15. Assert RESETN=0 mid-stall -> all outputs 0 next cycle, no error raised.

Source files
------------

// File: rtl/handshake_monitor_pkg.sv
// ----------------------------------------------------------------------------
// handshake_monitor_pkg
// Shared types for the ready/valid protocol monitor.
//   ch_state_t : per-channel FSM state (IDLE, STALLED)
//   err_code_t : first-error code reported by the top level
//   clogMin1   : $clog2 that never returns less than 1, for sizing index ports
// ----------------------------------------------------------------------------
package handshake_monitor_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      STALLED = 1'b1
   } ch_state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_DROP    = 2'd1,
      ERR_DATA    = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_t;

   // A single-channel monitor still needs a 1-bit channel index port.
   function automatic int clogMin1(input int n);
      if (n <= 1) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/handshake_monitor_ch.sv
// ----------------------------------------------------------------------------
// handshake_monitor_ch
// Watches one ready/valid channel. Tracks the stall state, remembers the
// payload offered when the stall began, counts stall cycles and accepted
// transfers, and raises single-cycle error pulses for the top level.
// Ports:
//   CLK, RESETN      clock, synchronous active-low reset
//   enable_i         when low, all state freezes and no pulses are raised
//   valid_i, ready_i handshake taps
//   data_i           payload tap
//   xferCount_o      saturating accepted-transfer count
//   dropPulse_o      valid withdrawn while stalled (this cycle)
//   dataPulse_o      payload changed while stalled (this cycle)
//   timeoutPulse_o   stall count reaches STALL_MAX on this cycle's update
// ----------------------------------------------------------------------------
module handshake_monitor_ch
   import handshake_monitor_pkg::*;
#(
   parameter int DATA_W    = 5,
   parameter int CNT_W     = 16,
   parameter int STALL_MAX = 15
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              enable_i,
   input  logic              valid_i,
   input  logic              ready_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [CNT_W-1:0]  xferCount_o,
   output logic              dropPulse_o,
   output logic              dataPulse_o,
   output logic              timeoutPulse_o
);

   localparam int STALL_W = (STALL_MAX < 1) ? 1 : $clog2(STALL_MAX + 1);
   localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_MAX);
   localparam logic [STALL_W-1:0] STALL_PRE   = STALL_W'(STALL_MAX - 1);
   localparam logic [STALL_W-1:0] STALL_ONE   = STALL_W'(1);

   ch_state_t          state_q;
   logic [DATA_W-1:0]  hold_q;
   logic [STALL_W-1:0] stallCnt_q;
   logic [CNT_W-1:0]   xferCnt_q;

   assign xferCount_o = xferCnt_q;

   // Error pulses are derived from the current state and taps. The timeout
   // pulse fires only on the update that moves the stall count onto
   // STALL_MAX; once saturated the count no longer changes, so it fires once
   // per stall episode. With STALL_MAX of 1 that update is the stall entry.
   always_comb begin
      dropPulse_o    = 1'b0;
      dataPulse_o    = 1'b0;
      timeoutPulse_o = 1'b0;
      if (enable_i) begin
         if (state_q == IDLE) begin
            timeoutPulse_o = valid_i & ~ready_i & (STALL_MAX == 1);
         end else if (!valid_i) begin
            dropPulse_o = 1'b1;
         end else begin
            dataPulse_o    = (data_i != hold_q);
            timeoutPulse_o = ~ready_i & (stallCnt_q == STALL_PRE);
         end
      end
   end

   // Channel FSM with its hold register, stall counter and transfer counter.
   // The hold register always follows the offered payload while stalled so a
   // single change is reported once rather than on every following cycle.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_q    <= IDLE;
         hold_q     <= '0;
         stallCnt_q <= '0;
         xferCnt_q  <= '0;
      end else if (enable_i) begin
         case (state_q)
            IDLE: begin
               if (valid_i) begin
                  if (ready_i) begin
                     if (xferCnt_q != '1) xferCnt_q <= xferCnt_q + CNT_W'(1);
                  end else begin
                     hold_q     <= data_i;
                     stallCnt_q <= STALL_ONE;
                     state_q    <= STALLED;
                  end
               end
            end
            STALLED: begin
               if (!valid_i) begin
                  stallCnt_q <= '0;
                  state_q    <= IDLE;
               end else begin
                  hold_q <= data_i;
                  if (ready_i) begin
                     if (xferCnt_q != '1) xferCnt_q <= xferCnt_q + CNT_W'(1);
                     stallCnt_q <= '0;
                     state_q    <= IDLE;
                  end else if (stallCnt_q != STALL_LIMIT) begin
                     stallCnt_q <= stallCnt_q + STALL_ONE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/handshake_monitor.sv
// ----------------------------------------------------------------------------
// handshake_monitor
// Bind-able protocol monitor for N_CH independent ready/valid channels.
// Each channel is watched by handshake_monitor_ch; this level keeps sticky
// error flags and captures the first error since reset or clear.
// Ports:
//   CLK, RESETN     clock, synchronous active-low reset
//   valid, ready    per-channel handshake taps
//   data            payloads, channel i in [i*DATA_W +: DATA_W]
//   enable          freezes all channel state when low
//   clear_errors    clears sticky flags and first-error capture
//   xfer_count      per-channel saturating transfer counts
//   err_drop/err_data/err_timeout  sticky per-channel error flags
//   any_error       OR of all sticky flags
//   first_err_ch/first_err_code    first error seen (code 0 means none)
// ----------------------------------------------------------------------------
module handshake_monitor
   import handshake_monitor_pkg::*;
#(
   parameter int N_CH      = 3,
   parameter int DATA_W    = 5,
   parameter int CNT_W     = 16,
   parameter int STALL_MAX = 15,
   localparam int CH_W     = clogMin1(N_CH)
) (
   input  logic                   CLK,
   input  logic                   RESETN,
   input  logic [N_CH-1:0]        valid,
   input  logic [N_CH-1:0]        ready,
   input  logic [N_CH*DATA_W-1:0] data,
   input  logic                   enable,
   input  logic                   clear_errors,
   output logic [N_CH*CNT_W-1:0]  xfer_count,
   output logic [N_CH-1:0]        err_drop,
   output logic [N_CH-1:0]        err_data,
   output logic [N_CH-1:0]        err_timeout,
   output logic                   any_error,
   output logic [CH_W-1:0]        first_err_ch,
   output logic [1:0]             first_err_code
);

   logic [N_CH-1:0] dropPulse, dataPulse, timeoutPulse;
   logic [N_CH-1:0] errDrop_q, errData_q, errTimeout_q;
   logic [N_CH-1:0] errDrop_d, errData_d, errTimeout_d;
   logic [CH_W-1:0] firstCh_q, firstCh_d, chBase;
   err_code_t       firstCode_q, firstCode_d, codeBase;

   for (genvar g = 0; g < N_CH; g++) begin : gCh
      handshake_monitor_ch #(
         .DATA_W   (DATA_W),
         .CNT_W    (CNT_W),
         .STALL_MAX(STALL_MAX)
      ) uCh (
         .CLK           (CLK),
         .RESETN        (RESETN),
         .enable_i      (enable),
         .valid_i       (valid[g]),
         .ready_i       (ready[g]),
         .data_i        (data[g*DATA_W +: DATA_W]),
         .xferCount_o   (xfer_count[g*CNT_W +: CNT_W]),
         .dropPulse_o   (dropPulse[g]),
         .dataPulse_o   (dataPulse[g]),
         .timeoutPulse_o(timeoutPulse[g])
      );
   end

   // Clear is applied first and new pulses are OR-ed in afterwards, so an
   // error arriving together with clear_errors survives and can become the
   // first error. The scan runs from the top channel down so the lowest
   // channel wins; within a channel drop beats data beats timeout.
   always_comb begin
      errDrop_d    = (clear_errors ? '0 : errDrop_q)    | dropPulse;
      errData_d    = (clear_errors ? '0 : errData_q)    | dataPulse;
      errTimeout_d = (clear_errors ? '0 : errTimeout_q) | timeoutPulse;
      codeBase     = clear_errors ? ERR_NONE : firstCode_q;
      chBase       = clear_errors ? '0 : firstCh_q;
      firstCode_d  = codeBase;
      firstCh_d    = chBase;
      if (codeBase == ERR_NONE) begin
         for (int i = N_CH - 1; i >= 0; i--) begin
            if (dropPulse[i]) begin
               firstCode_d = ERR_DROP;
               firstCh_d   = CH_W'(i);
            end else if (dataPulse[i]) begin
               firstCode_d = ERR_DATA;
               firstCh_d   = CH_W'(i);
            end else if (timeoutPulse[i]) begin
               firstCode_d = ERR_TIMEOUT;
               firstCh_d   = CH_W'(i);
            end
         end
      end
   end

   // Sticky error state; reset also masks any pulse seen in the reset cycle.
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         errDrop_q    <= '0;
         errData_q    <= '0;
         errTimeout_q <= '0;
         firstCh_q    <= '0;
         firstCode_q  <= ERR_NONE;
      end else begin
         errDrop_q    <= errDrop_d;
         errData_q    <= errData_d;
         errTimeout_q <= errTimeout_d;
         firstCh_q    <= firstCh_d;
         firstCode_q  <= firstCode_d;
      end
   end

   assign err_drop       = errDrop_q;
   assign err_data       = errData_q;
   assign err_timeout    = errTimeout_q;
   assign any_error      = |{errDrop_q, errData_q, errTimeout_q};
   assign first_err_ch   = firstCh_q;
   assign first_err_code = firstCode_q;

endmodule

// File: tb/tb_handshake_monitor.sv
// ----------------------------------------------------------------------------
// tb_handshake_monitor
// Directed bench for handshake_monitor with three channels, 5-bit payloads,
// a 4-bit transfer counter (so saturation is reachable) and STALL_MAX of 15.
// ----------------------------------------------------------------------------
module tb_handshake_monitor;

   localparam int N_CH      = 3;
   localparam int DATA_W    = 5;
   localparam int CNT_W     = 4;
   localparam int STALL_MAX = 15;

   logic                   CLK;
   logic                   RESETN;
   logic [N_CH-1:0]        valid;
   logic [N_CH-1:0]        ready;
   logic [N_CH*DATA_W-1:0] data;
   logic                   enable;
   logic                   clear_errors;
   logic [N_CH*CNT_W-1:0]  xfer_count;
   logic [N_CH-1:0]        err_drop;
   logic [N_CH-1:0]        err_data;
   logic [N_CH-1:0]        err_timeout;
   logic                   any_error;
   logic [1:0]             first_err_ch;
   logic [1:0]             first_err_code;

   int compareCount = 0;
   int failCount    = 0;

   handshake_monitor #(
      .N_CH     (N_CH),
      .DATA_W   (DATA_W),
      .CNT_W    (CNT_W),
      .STALL_MAX(STALL_MAX)
   ) dut (
      .CLK           (CLK),
      .RESETN        (RESETN),
      .valid         (valid),
      .ready         (ready),
      .data          (data),
      .enable        (enable),
      .clear_errors  (clear_errors),
      .xfer_count    (xfer_count),
      .err_drop      (err_drop),
      .err_data      (err_data),
      .err_timeout   (err_timeout),
      .any_error     (any_error),
      .first_err_ch  (first_err_ch),
      .first_err_code(first_err_code)
   );

   // Free-running 10 ns clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Advance one clock and settle past the edge before anything is sampled
   // or driven, keeping both away from the active edge.
   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   // Drive one channel's handshake taps.
   task automatic applyStimulus(input int ch, input logic v, input logic r,
                                input logic [DATA_W-1:0] d);
      valid[ch] = v;
      ready[ch] = r;
      data[ch*DATA_W +: DATA_W] = d;
   endtask

   // One comparison against a bench-computed expected value.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Linear sequence of directed steps.
   initial begin
      RESETN = 1'b0; valid = '0; ready = '0; data = '0;
      enable = 1'b1; clear_errors = 1'b0;
      tick(2);
      checkOutput("reset_xfer",  32'(xfer_count), 32'h0);
      checkOutput("reset_flags", 32'({err_drop, err_data, err_timeout}), 32'h0);
      checkOutput("reset_any",   32'(any_error), 32'h0);
      checkOutput("reset_code",  32'({first_err_ch, first_err_code}), 32'h0);
      RESETN = 1'b1;

      // Ten back-to-back transfers on ch0.
      applyStimulus(0, 1'b1, 1'b1, 5'h11);
      tick(10);
      applyStimulus(0, 1'b0, 1'b0, 5'h00);
      tick();
      checkOutput("b2b_xfer0", 32'(xfer_count[0 +: CNT_W]), 32'd10);
      checkOutput("b2b_any",   32'(any_error), 32'h0);
      checkOutput("b2b_code",  32'(first_err_code), 32'd0);

      // ch1 stalls three cycles with stable data, then is accepted.
      applyStimulus(1, 1'b1, 1'b0, 5'h0A);
      tick(3);
      applyStimulus(1, 1'b1, 1'b1, 5'h0A);
      tick();
      checkOutput("stall_ok_xfer1", 32'(xfer_count[CNT_W +: CNT_W]), 32'd1);
      checkOutput("stall_ok_any",   32'(any_error), 32'h0);

      // ch1 stalls two cycles then withdraws valid.
      applyStimulus(1, 1'b1, 1'b0, 5'h0B);
      tick(2);
      checkOutput("pre_drop_any", 32'(any_error), 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 5'h0B);
      tick();
      checkOutput("drop1_flag", 32'(err_drop), 32'b010);
      checkOutput("drop1_first", 32'({first_err_ch, first_err_code}), {28'h0, 2'd1, 2'd1});
      checkOutput("drop1_xfer1", 32'(xfer_count[CNT_W +: CNT_W]), 32'd1);

      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
      checkOutput("clear_any",  32'(any_error), 32'h0);
      checkOutput("clear_code", 32'(first_err_code), 32'd0);

      // ch2 changes payload while stalled.
      applyStimulus(2, 1'b1, 1'b0, 5'h03);
      tick();
      applyStimulus(2, 1'b1, 1'b0, 5'h04);
      tick();
      checkOutput("data2_flag",  32'(err_data), 32'b100);
      checkOutput("data2_first", 32'({first_err_ch, first_err_code}), {28'h0, 2'd2, 2'd2});

      // Simultaneous ch0 drop and ch2 data change: ch0 must be captured.
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
      applyStimulus(0, 1'b1, 1'b0, 5'h07);
      tick();
      applyStimulus(0, 1'b0, 1'b0, 5'h07);
      applyStimulus(2, 1'b1, 1'b0, 5'h05);
      tick();
      checkOutput("simul_drop",  32'(err_drop), 32'b001);
      checkOutput("simul_data",  32'(err_data), 32'b100);
      checkOutput("simul_first", 32'({first_err_ch, first_err_code}), {28'h0, 2'd0, 2'd1});
      applyStimulus(2, 1'b0, 1'b0, 5'h05);
      tick();
      checkOutput("later_drop2", 32'(err_drop), 32'b101);
      checkOutput("later_first", 32'({first_err_ch, first_err_code}), {28'h0, 2'd0, 2'd1});

      // ch0 stall timeout: fires on the 15th stall update and only once.
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
      applyStimulus(0, 1'b1, 1'b0, 5'h07);
      tick(14);
      checkOutput("tmo_before", 32'(err_timeout), 32'b000);
      tick();
      checkOutput("tmo_fire",  32'(err_timeout), 32'b001);
      checkOutput("tmo_first", 32'({first_err_ch, first_err_code}), {28'h0, 2'd0, 2'd3});
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
      tick(4);
      checkOutput("tmo_once", 32'(err_timeout), 32'b000);
      checkOutput("tmo_once_code", 32'(first_err_code), 32'd0);
      applyStimulus(0, 1'b1, 1'b1, 5'h07);
      tick();
      applyStimulus(0, 1'b0, 1'b0, 5'h00);
      checkOutput("tmo_accept_xfer0", 32'(xfer_count[0 +: CNT_W]), 32'd11);

      // Existing ch2 error, then clear in the same cycle as a ch1 drop.
      applyStimulus(2, 1'b1, 1'b0, 5'h01);
      tick();
      applyStimulus(2, 1'b0, 1'b0, 5'h01);
      tick();
      checkOutput("pre_clr_first", 32'({first_err_ch, first_err_code}), {28'h0, 2'd2, 2'd1});
      applyStimulus(1, 1'b1, 1'b0, 5'h02);
      tick();
      applyStimulus(1, 1'b0, 1'b0, 5'h02);
      clear_errors = 1'b1;
      tick();
      clear_errors = 1'b0;
      checkOutput("clr_win_drop",  32'(err_drop), 32'b010);
      checkOutput("clr_win_first", 32'({first_err_ch, first_err_code}), {28'h0, 2'd1, 2'd1});

      // Counters freeze while enable is low.
      enable = 1'b0;
      applyStimulus(1, 1'b1, 1'b1, 5'h02);
      tick(2);
      checkOutput("disabled_xfer1", 32'(xfer_count[CNT_W +: CNT_W]), 32'd1);
      enable = 1'b1;
      tick();
      applyStimulus(1, 1'b0, 1'b0, 5'h00);
      checkOutput("enabled_xfer1", 32'(xfer_count[CNT_W +: CNT_W]), 32'd2);

      // ch0 counter saturates at 15 (4-bit counter).
      applyStimulus(0, 1'b1, 1'b1, 5'h09);
      tick(20);
      applyStimulus(0, 1'b0, 1'b0, 5'h00);
      checkOutput("sat_xfer0", 32'(xfer_count[0 +: CNT_W]), 32'd15);

      // Reset during a ch2 stall while valid drops: nothing raised.
      applyStimulus(2, 1'b1, 1'b0, 5'h09);
      tick();
      RESETN = 1'b0;
      applyStimulus(2, 1'b0, 1'b0, 5'h09);
      tick();
      checkOutput("rst_mid_xfer",  32'(xfer_count), 32'h0);
      checkOutput("rst_mid_flags", 32'({err_drop, err_data, err_timeout}), 32'h0);
      checkOutput("rst_mid_first", 32'({first_err_ch, first_err_code, any_error}), 32'h0);
      RESETN = 1'b1;
      tick();
      checkOutput("post_rst_drop", 32'(err_drop), 32'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
